// File: rtl/rx_controller_pkg.sv
// Shared constants for the receive path: decoder packet framing and the controller state encoding.
// Interval values are in system clock cycles between decoder pulses.
package rx_controller_pkg;

    localparam int PACKET_SIZE   = 8;
    localparam int INTERVAL_HIGH = 8;
    localparam int INTERVAL_LOW  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        FLUSH    = 2'd2,
        DISABLED = 2'd3
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_controller_packet_fifo.sv
// First-word-fall-through packet FIFO; head visible the cycle after the write, zero when empty.
// A push into a full FIFO is taken only if a pop happens in the same cycle.
module packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, the write lands in the slot being popped; the head is read combinationally first.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rx_controller.sv
// Receive controller: mirrors decoder framing, aborts stalled packets with a decoder reset pulse,
// and queues completed packets for a valid/ready consumer with overflow/timeout status.
module rx_controller
    import rx_controller_pkg::*;
#(
    parameter int TIMEOUT      = INTERVAL_HIGH * 2,
    parameter int RESET_CYCLES = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   dec_signal,
    input  logic [PACKET_SIZE-1:0] dec_data,
    input  logic                   dec_irq,
    output logic                   dec_reset,
    output logic [PACKET_SIZE-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clear_status,
    output logic                   overflow,
    output logic [7:0]             timeout_count
);

    localparam int GW = $clog2(TIMEOUT + 1);
    localparam int FW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    rx_state_t   state;
    logic [GW-1:0] gap;
    logic [GW-1:0] gap_inc;
    logic [FW-1:0] flush_cnt;
    logic        irq_q;
    logic        irq_rise;
    logic        push;
    logic        pop;
    logic        start_flush;
    logic        timeout_hit;
    logic        fifo_empty;
    logic        fifo_full;

    assign irq_rise  = dec_irq & ~irq_q;
    assign gap_inc   = (gap == '1) ? gap : gap + 1'b1;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        push        = 1'b0;
        start_flush = 1'b0;
        timeout_hit = 1'b0;
        if (!enable) begin
            start_flush = (state == IDLE) || (state == RECV);
        end else if (state == RECV) begin
            // A completing packet beats a coincident gap timeout.
            if (irq_rise) begin
                push = 1'b1;
            end else if (!dec_signal && (gap_inc >= GW'(TIMEOUT))) begin
                timeout_hit = 1'b1;
                start_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            gap           <= '0;
            flush_cnt     <= '0;
            irq_q         <= 1'b0;
            dec_reset     <= 1'b0;
            overflow      <= 1'b0;
            timeout_count <= '0;
        end else begin
            irq_q <= dec_irq;

            // The decoder reset pulse runs to completion independently of later state changes.
            if (start_flush) begin
                dec_reset <= 1'b1;
                flush_cnt <= FW'(RESET_CYCLES - 1);
            end else if (dec_reset) begin
                if (flush_cnt == '0) dec_reset <= 1'b0;
                else                 flush_cnt <= flush_cnt - 1'b1;
            end

            if (!enable) begin
                state <= DISABLED;
            end else begin
                case (state)
                    IDLE: begin
                        if (dec_signal) begin
                            gap   <= '0;
                            state <= RECV;
                        end
                    end
                    RECV: begin
                        gap <= dec_signal ? '0 : gap_inc;
                        if (push)             state <= IDLE;
                        else if (timeout_hit) state <= FLUSH;
                    end
                    FLUSH: begin
                        if (dec_reset && (flush_cnt == '0)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (clear_status) begin
                overflow      <= 1'b0;
                timeout_count <= '0;
            end else begin
                if (push && fifo_full && !pop) overflow <= 1'b1;
                if (timeout_hit) timeout_count <= sat_inc8(timeout_count);
            end
        end
    end

    packet_fifo #(
        .WIDTH(PACKET_SIZE),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(dec_data),
        .pop      (pop),
        .head     (out_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_rx_controller.sv
// Randomized decoder traffic against a queue-based reference of the receive controller,
// plus directed framing, overflow, disable and asynchronous reset scenarios.
module tb_rx_controller;
    import rx_controller_pkg::*;

    localparam int TO    = INTERVAL_HIGH * 2;
    localparam int RC    = 2;
    localparam int DEPTH = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   enable = 1'b1;
    logic                   dec_signal = 1'b0;
    logic [PACKET_SIZE-1:0] dec_data = '0;
    logic                   dec_irq = 1'b0;
    logic                   dec_reset;
    logic [PACKET_SIZE-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   clear_status = 1'b0;
    logic                   overflow;
    logic [7:0]             timeout_count;

    rx_controller #(.TIMEOUT(TO), .RESET_CYCLES(RC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .dec_signal(dec_signal),
        .dec_data(dec_data), .dec_irq(dec_irq), .dec_reset(dec_reset),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clear_status(clear_status), .overflow(overflow), .timeout_count(timeout_count)
    );

    always #5 clock = ~clock;

    int errs = 0;
    int checks = 0;

    // Stimulus knobs: ready in percent, clear and disable in per-mille.
    int rdy_pct = 100;
    int clr_pm  = 0;
    int dis_pm  = 0;

    // Reference model: mode names, unbounded gap count, a queue for the FIFO.
    localparam int M_IDLE = 0, M_RECV = 1, M_FLUSH = 2, M_OFF = 3;
    int                     m_mode;
    int                     m_gap;
    int                     m_rst_rem;
    bit                     m_irq_prev;
    bit                     m_ovf;
    int                     m_tc;
    logic [PACKET_SIZE-1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_gap = 0; m_rst_rem = 0; m_irq_prev = 0;
        m_ovf = 0; m_tc = 0; m_q.delete();
    endtask

    task automatic model_step();
        bit rise, pop, push, pulse, tmo;
        rise = dec_irq && !m_irq_prev;
        m_irq_prev = dec_irq;
        pop = (m_q.size() > 0) && out_ready;
        push = 0; pulse = 0; tmo = 0;
        if (!enable) begin
            pulse = (m_mode == M_IDLE) || (m_mode == M_RECV);
            m_mode = M_OFF;
        end else if (m_mode == M_IDLE) begin
            if (dec_signal) begin m_gap = 0; m_mode = M_RECV; end
        end else if (m_mode == M_RECV) begin
            m_gap = dec_signal ? 0 : m_gap + 1;
            if (rise) begin
                push = 1; m_mode = M_IDLE;
            end else if (!dec_signal && m_gap >= TO) begin
                tmo = 1; pulse = 1; m_mode = M_FLUSH;
            end
        end else if (m_mode == M_FLUSH) begin
            if (m_rst_rem == 1) m_mode = M_IDLE;
        end else begin
            m_mode = M_IDLE;
        end
        if (pulse) m_rst_rem = RC;
        else if (m_rst_rem > 0) m_rst_rem--;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(dec_data);
            else if (!clear_status) m_ovf = 1;
        end
        if (clear_status) begin
            m_ovf = 0; m_tc = 0;
        end else if (tmo && m_tc < 255) begin
            m_tc++;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : '0);
        chk("dec_reset", dec_reset, m_rst_rem > 0);
        chk("overflow", overflow, m_ovf);
        chk("timeout_count", timeout_count, m_tc);
    endtask

    // Called at posedge+1: randomizes handshake/status inputs, advances one edge, checks.
    task automatic step();
        out_ready    = ($urandom_range(99) < rdy_pct);
        clear_status = ($urandom_range(999) < clr_pm);
        enable       = !($urandom_range(999) < dis_pm);
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_packet(input bit trunc, input int irq_rdy);
        int n, g, saved;
        dec_irq = 0; dec_signal = 1; step(); dec_signal = 0;
        n = trunc ? 3 : PACKET_SIZE;
        for (int i = 0; i < n; i++) begin
            g = (i % 2) ? INTERVAL_HIGH : INTERVAL_LOW;
            if (!trunc && $urandom_range(99) < 4) g = TO - 1 + $urandom_range(1);
            repeat (g) step();
            dec_signal = 1; step(); dec_signal = 0;
        end
        if (trunc) begin
            repeat (TO + 4) step();
        end else begin
            step();
            dec_data = PACKET_SIZE'($urandom);
            dec_irq = 1;
            saved = rdy_pct;
            if (irq_rdy >= 0) rdy_pct = irq_rdy * 100;
            step();
            rdy_pct = saved;
            repeat (2) step();
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_dec_reset", dec_reset, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout_count", timeout_count, 0);
        @(negedge clock) reset = 0;
        @(posedge clock); #1;

        // Single packet, then truncated packet followed by a good one.
        rdy_pct = 100;
        send_packet(0, -1);
        send_packet(1, -1);
        send_packet(0, -1);

        // Overflow with a stalled consumer, then a push coinciding with a pop while full.
        rdy_pct = 0;
        repeat (5) send_packet(0, -1);
        send_packet(0, 1);
        rdy_pct = 100;
        repeat (8) step();

        // Disable mid-packet.
        dec_irq = 0; dec_signal = 1; step(); dec_signal = 0;
        repeat (2) begin repeat (INTERVAL_LOW) step(); dec_signal = 1; step(); dec_signal = 0; end
        dis_pm = 1000; repeat (4) step();
        dis_pm = 0; repeat (2) step();
        send_packet(0, -1);

        // Randomized traffic.
        for (int p = 0; p < 150; p++) begin
            rdy_pct = $urandom_range(100);
            clr_pm  = 10;
            dis_pm  = 4;
            send_packet($urandom_range(9) == 0, -1);
        end
        clr_pm = 0; dis_pm = 0;

        // Asynchronous reset while the decoder reset pulse is active.
        rdy_pct = 0;
        send_packet(0, -1);
        dec_irq = 0; dec_signal = 1; step(); dec_signal = 0;
        repeat (3) begin repeat (INTERVAL_LOW) step(); dec_signal = 1; step(); dec_signal = 0; end
        for (int k = 0; k < TO + 10 && !dec_reset; k++) step();
        chk("flush_seen", dec_reset, 1);
        #2 reset = 1;
        #1;
        chk("async_dec_reset", dec_reset, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_overflow", overflow, 0);
        chk("async_timeout_count", timeout_count, 0);
        model_reset();
        @(negedge clock) reset = 0;
        @(posedge clock); #1;
        rdy_pct = 100;
        send_packet(0, -1);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
